mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares one 8x16 register-file memory (rows written on a gated clock, combinational/latched read) between a CPU port (A) and a loader/debug port (B).
- Each port has a req/gnt/ack handshake.
- The block generates glitch-safe cs/we/addr/din sequencing toward the memory and returns registered read data.
- Sits between the CPU core, the serial loader and the memory in the SoC.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one register-file memory between CPU port A and loader port B. Accepted reads ack 2 cycles later, writes 4, out-of-range 1.
// Requesters hold req with a stable command until gnt, and only one transaction is in flight at a time.
module mem_arbiter #(
    parameter int ROWS       = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_ack,
    output logic        a_err,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_ack,
    output logic        b_err,

    output logic [15:0] rdata,

    output logic        mem_cs,
    output logic        mem_we,
    output logic [2:0]  mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WSETUP  = 3'd2,
        WSTROBE = 3'd3,
        WHOLD   = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [3:0] ROWS_L = 4'(ROWS);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;      // 0 = port A, 1 = port B
    logic        last_b_q, last_b_d;    // last grant went to B, so A is favoured next
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic        a_gnt_q, a_gnt_d;
    logic        b_gnt_q, b_gnt_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic        a_err_q, a_err_d;
    logic        b_err_q, b_err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_cs_q, mem_cs_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;

    logic        pick_b;
    logic        sel_we;
    logic [2:0]  sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_oor;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_b_d   = last_b_q;
        we_d       = we_q;
        err_d      = err_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_err_d    = 1'b0;
        b_err_d    = 1'b0;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        pick_b    = b_req && (!a_req || (FIXED_PRIO == 0 && !last_b_q));
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        sel_oor   = {1'b0, sel_addr} >= ROWS_L;

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    owner_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = sel_we;
                    err_d    = sel_oor;
                    a_gnt_d  = !pick_b;
                    b_gnt_d  = pick_b;
                    if (sel_oor) begin
                        state_d = RESP;
                    end else begin
                        mem_addr_d = sel_addr;
                        if (sel_we) begin
                            mem_din_d = sel_wdata;
                            state_d   = WSETUP;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                rdata_d = mem_dout;
                state_d = RESP;
            end
            WSETUP:  state_d = WSTROBE;
            WSTROBE: state_d = WHOLD;
            WHOLD:   state_d = RESP;
            RESP: begin
                a_ack_d = !owner_q;
                b_ack_d = owner_q;
                a_err_d = !owner_q && err_q;
                b_err_d = owner_q && err_q;
                // An out-of-range read still completes as a read, returning zero.
                if (err_q && !we_q) begin
                    rdata_d = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobe sits strictly inside the cs window so addr/din settle a cycle either side of it.
        mem_cs_d = (state_d == RD) || (state_d == WSETUP) ||
                   (state_d == WSTROBE) || (state_d == WHOLD);
        mem_we_d = (state_d == WSTROBE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_b_q   <= 1'b1;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            rdata_q    <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_b_q   <= last_b_d;
            we_q       <= we_d;
            err_q      <= err_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
            rdata_q    <= rdata_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_err    = a_err_q;
    assign b_err    = b_err_q;
    assign rdata    = rdata_q;
    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-schedule model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;
    localparam int ROWS = 4;
    localparam int NCYC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
    logic [15:0] rdata;
    logic        mem_cs, mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_din, mem_dout;

    logic        a_gnt_f, a_ack_f, a_err_f, b_gnt_f, b_ack_f, b_err_f;
    logic [15:0] rdata_f, mem_din_f;
    logic        mem_cs_f, mem_we_f;
    logic [2:0]  mem_addr_f;

    mem_arbiter #(.ROWS(ROWS), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_err(b_err),
        .rdata(rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    mem_arbiter #(.ROWS(ROWS), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt_f), .a_ack(a_ack_f), .a_err(a_err_f),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt_f), .b_ack(b_ack_f), .b_err(b_err_f),
        .rdata(rdata_f),
        .mem_cs(mem_cs_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f), .mem_din(mem_din_f),
        .mem_dout(16'h0000)
    );

    // Physical register file; its write clock is gated off while the system is in reset.
    logic [15:0] phys [8];
    always @(posedge clk) begin
        if (rst_n && mem_cs && mem_we) phys[mem_addr] <= mem_din;
    end
    assign mem_dout = phys[mem_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: each accept schedules what every output must show in later cycles.
    typedef struct packed {
        logic        ga, gb, ka, kb, ea, eb, cs, we, chk_din, rd_upd;
        logic [2:0]  addr;
        logic [15:0] din;
        logic [15:0] rd_val;
    } exp_t;

    exp_t        sched [NCYC];
    int          cyc = 0;
    bit          model_on = 1'b0;
    bit          last_b;
    int          next_free;
    logic [15:0] model_mem [8];
    logic [15:0] exp_rdata;
    int          commit_cyc = -1;
    logic [2:0]  commit_addr;
    logic [15:0] commit_data;
    bit          m_pb, m_we, m_oor;
    logic [2:0]  m_addr;
    logic [15:0] m_wd;
    int          m_lat;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            model_on = 1'b1;
            for (int j = cyc; j < NCYC; j++) sched[j] = '0;
            last_b     = 1'b1;
            next_free  = cyc + 1;
            exp_rdata  = 16'h0;
            commit_cyc = -1;
        end else if (model_on && cyc + 8 < NCYC) begin
            if (sched[cyc].rd_upd) exp_rdata = sched[cyc].rd_val;
            if (commit_cyc == cyc) model_mem[commit_addr] = commit_data;
            if (cyc >= next_free && (a_req || b_req)) begin
                if (a_req && b_req) m_pb = !last_b;
                else                m_pb = b_req;
                m_we   = m_pb ? b_we : a_we;
                m_addr = m_pb ? b_addr : a_addr;
                m_wd   = m_pb ? b_wdata : a_wdata;
                m_oor  = int'(m_addr) >= ROWS;
                m_lat  = m_oor ? 1 : (m_we ? 4 : 2);
                if (m_pb) sched[cyc].gb = 1'b1; else sched[cyc].ga = 1'b1;
                if (m_pb) begin
                    sched[cyc + m_lat].kb = 1'b1;
                    sched[cyc + m_lat].eb = m_oor;
                end else begin
                    sched[cyc + m_lat].ka = 1'b1;
                    sched[cyc + m_lat].ea = m_oor;
                end
                if (!m_oor) begin
                    for (int j = 0; j <= m_lat - 2; j++) begin
                        sched[cyc + j].cs      = 1'b1;
                        sched[cyc + j].addr    = m_addr;
                        sched[cyc + j].chk_din = m_we;
                        sched[cyc + j].din     = m_wd;
                    end
                end
                if (m_we && !m_oor) begin
                    sched[cyc + 1].we = 1'b1;
                    commit_cyc  = cyc + 2;
                    commit_addr = m_addr;
                    commit_data = m_wd;
                end
                if (!m_we) begin
                    sched[cyc + 1].rd_upd = 1'b1;
                    sched[cyc + 1].rd_val = m_oor ? 16'h0 : model_mem[m_addr];
                end
                last_b    = m_pb;
                next_free = cyc + m_lat + 1;
            end
        end
    end

    exp_t e_now;
    always @(negedge clk) begin
        if (model_on && cyc < NCYC) begin
            e_now = sched[cyc];
            chk("a_gnt", a_gnt, e_now.ga);
            chk("b_gnt", b_gnt, e_now.gb);
            chk("a_ack", a_ack, e_now.ka);
            chk("b_ack", b_ack, e_now.kb);
            chk("a_err", a_err, e_now.ea);
            chk("b_err", b_err, e_now.eb);
            chk("mem_cs", mem_cs, e_now.cs);
            chk("mem_we", mem_we, e_now.we);
            if (e_now.cs) chk("mem_addr", mem_addr, e_now.addr);
            if (e_now.chk_din) chk("mem_din", mem_din, e_now.din);
            chk("rdata", rdata, exp_rdata);
        end
    end

    int we_cycles = 0;
    int cs_cycles = 0;
    always @(negedge clk) begin
        if (mem_we) we_cycles++;
        if (mem_cs) cs_cycles++;
    end

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [2:0] addr, input logic [15:0] wd);
        if (!port) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
        else       begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
    endtask

    // Issues one transaction and returns gnt-to-ack latency in cycles (-1 on timeout).
    task automatic txn(input bit port, input bit we, input logic [2:0] addr, input logic [15:0] wd,
                       output int lat, output logic [15:0] rd, output logic err);
        int  n;
        bit  seen;
        @(negedge clk);
        drive(port, 1'b1, we, addr, wd);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            seen = port ? b_gnt : a_gnt;
        end
        drive(port, 1'b0, we, addr, wd);
        lat = -1; rd = 16'hxxxx; err = 1'bx;
        if (!seen) begin
            checks++; failures++;
            $display("FAIL gnt_timeout: port %0d got no gnt within 20 cycles", port);
            return;
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            seen = port ? b_ack : a_ack;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL ack_timeout: port %0d got no ack within 20 cycles", port);
            return;
        end
        lat = n; rd = rdata; err = port ? b_err : a_err;
    endtask

    int          lat, ng, fa, fb, acks;
    logic [15:0] rd;
    logic        err;
    int          seq [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            phys[i]      = 16'h1000 + 16'(i);
            model_mem[i] = 16'h1000 + 16'(i);
        end
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {a_gnt, b_gnt}, 0);
        chk("rst_ack", {a_ack, b_ack}, 0);
        chk("rst_err", {a_err, b_err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_ctl", {mem_cs, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        rst_n = 1'b1;

        // Write then read back through the other port.
        we_cycles = 0;
        txn(0, 1'b1, 3'd2, 16'hBEEF, lat, rd, err);
        chk("wr_latency", lat, 4);
        chk("wr_err", err, 0);
        chk("wr_we_pulses", we_cycles, 1);
        chk("wr_landed", phys[2], 16'hBEEF);
        txn(1, 1'b0, 3'd2, 16'h0, lat, rd, err);
        chk("rd_latency", lat, 2);
        chk("rd_data", rd, 16'hBEEF);
        chk("rd_err", err, 0);

        // Continuous contention from a fresh reset: round-robin vs fixed priority.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 3'd0, 16'h0);
        drive(1, 1'b1, 1'b0, 3'd1, 16'h0);
        ng = 0; fa = 0; fb = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (a_gnt && ng < 8) begin seq[ng] = 0; ng++; end
            if (b_gnt && ng < 8) begin seq[ng] = 1; ng++; end
            if (a_gnt_f) fa++;
            if (b_gnt_f) fb++;
        end
        drive(0, 1'b0, 1'b0, 3'd0, 16'h0);
        drive(1, 1'b0, 1'b0, 3'd1, 16'h0);
        chk("rr_grant_count", ng, 5);
        chk("rr_order", {seq[0][0], seq[1][0], seq[2][0], seq[3][0]}, 4'b0101);
        chk("fp_a_grants", fa, 5);
        chk("fp_b_grants", fb, 0);
        repeat (5) @(negedge clk);

        // Out-of-range read: never touches memory, zeroes rdata.
        cs_cycles = 0;
        txn(1, 1'b0, 3'd5, 16'h0, lat, rd, err);
        chk("oor_latency", lat, 1);
        chk("oor_err", err, 1);
        chk("oor_rdata", rd, 0);
        chk("oor_no_cs", cs_cycles, 0);

        // Reset during the write strobe aborts the write.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'd1, 16'h1234);
        ng = 0;
        while (!a_gnt && ng < 20) begin @(negedge clk); ng++; end
        drive(0, 1'b0, 1'b1, 3'd1, 16'h1234);
        @(negedge clk);
        chk("abort_strobe_seen", mem_we, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_we_low", mem_we, 0);
        chk("abort_cs_low", mem_cs, 0);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin @(negedge clk); if (a_ack || b_ack) acks++; end
        chk("abort_no_ack", acks, 0);
        txn(0, 1'b0, 3'd1, 16'h0, lat, rd, err);
        chk("abort_old_data", rd, 16'h1001);

        // Two writes then two reads; an out-of-range write leaves rdata alone.
        txn(0, 1'b1, 3'd3, 16'hA5A5, lat, rd, err);
        chk("w3_latency", lat, 4);
        txn(1, 1'b1, 3'd0, 16'h5A5A, lat, rd, err);
        chk("w0_latency", lat, 4);
        txn(1, 1'b0, 3'd3, 16'h0, lat, rd, err);
        chk("r3_data", rd, 16'hA5A5);
        txn(0, 1'b0, 3'd0, 16'h0, lat, rd, err);
        chk("r0_data", rd, 16'h5A5A);
        txn(0, 1'b1, 3'd6, 16'hFFFF, lat, rd, err);
        chk("oor_wr_err", err, 1);
        chk("oor_wr_rdata_kept", rd, 16'h5A5A);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
